fetch_queue_nw: RTL
===================

// Module: fetch_queue_nw
// PURPOSE
//   N-wide instruction fetch queue for the superscalar core; generalises the fixed 2-wide imem port pair.
//   Generates ISSUE_W consecutive word addresses per fetch group and drives ISSUE_W imem read ports.
//   Buffers returned instructions with their PCs in a DEPTH-entry circular queue.
//   Decode dequeues 0..ISSUE_W oldest entries per cycle. A branch redirect flushes the queue.
// PARAMETERS
//   ISSUE_W   2       fetch/dequeue lanes per cycle (>=1)
//   DEPTH     8       queue entries; power of 2, >= 2*ISSUE_W
//   ADDR_W    12      imem word-address width
//   INSN_W    32      instruction width
//   RESET_PC  0       first fetch address after reset
// PORTS
//   clock           in   1                      master clock, rising edge
//   reset           in   1                      asynchronous, active-high
//   redirect_valid  in   1                      flush and restart fetch at redirect_pc
//   redirect_pc     in   ADDR_W                 new fetch word address
//   imem_addr       out  ISSUE_W*ADDR_W         lane i address = fetch_pc+i (mod 2^ADDR_W)
//   imem_rden       out  ISSUE_W                per-lane read enable
//   imem_q          in   ISSUE_W*INSN_W         per-lane read data, valid 1 cycle after rden
//   deq_count       in   $clog2(ISSUE_W+1)      entries consumed by decode this cycle
//   out_valid       out  ISSUE_W                lane i valid iff i < count
//   out_insn        out  ISSUE_W*INSN_W         lane 0 = oldest entry
//   out_pc          out  ISSUE_W*ADDR_W         PC of each out lane
//   count           out  $clog2(DEPTH+1)        occupied entries
// BEHAVIOUR
//   - Reset (async): fetch_pc=RESET_PC; head, tail, count=0; pend=0. imem_rden=0 and out_valid=0 while reset is high.
//   - Fetch issue in cycle k: fires iff !redirect_valid && count + (pend?ISSUE_W:0) + ISSUE_W <= DEPTH.
//     - Uses count before this cycle's dequeue, which is conservative.
//     - On fire: rden of all lanes=1, imem_addr=fetch_pc+i, pend<=1, fetch_pc<=fetch_pc+ISSUE_W (wraps).
//     - Otherwise: rden=0, pend<=0.
//   - Response: in cycle k+1 with pend=1 and no redirect, push imem_q lanes 0..ISSUE_W-1 in lane order at tail, with PCs.
//   - Latency: from issue to out_valid of that group is 2 clock edges (insn visible in cycle k+2).
//   - Dequeue: pop = min(deq_count, count). Over-request is clamped, not an error.
//     - head<=head+pop; count<=count+push-pop in the same edge.
//   - Pointers wrap mod DEPTH. Simultaneous push and pop are legal at any occupancy, including full and empty.
//   - out lanes are combinational from head..head+ISSUE_W-1. out_insn/out_pc of invalid lanes are don't-care.
//   - Redirect (highest priority), effective at the edge:
//     - count, head, tail <= 0; pend<=0, so the in-flight response is squashed.
//     - fetch_pc<=redirect_pc; no fetch is issued in the redirect cycle.
//     - The cycle after a redirect issues from redirect_pc if space allows.
//     - Any deq_count in the redirect cycle is ignored.
//   - Reset mid-fetch discards any pending response. imem_q after reset is ignored until a new rden.
// CONFIGURATION
//   FETCH_ALIGN_EN defined:
//     - Fetch groups are aligned: a redirect sets fetch_pc = redirect_pc & ~(ISSUE_W-1). ISSUE_W must be a power of 2.
//     - The first response after a redirect pushes only lanes >= (redirect_pc mod ISSUE_W), with push = ISSUE_W-offset.
//     - Later groups push all lanes.
//   FETCH_ALIGN_EN undefined:
//     - Groups start exactly at redirect_pc. Every response pushes ISSUE_W entries.
// TESTING
//   1. Reset, RESET_PC=0, deq_count=0.
//      -> rden=2'b11 at addr 0,1 then 2,3...
//      -> count 2,4,6,8; fetch stops at count=8; never exceeds DEPTH.
//   2. Queue full (8), deq_count=2 each cycle.
//      -> steady state: out lanes show PCs 0/1, 2/3, ... in order.
//      -> count oscillates within 4..8; no lost or duplicated PC.
//   3. Pend=1 (addr 4,5 in flight), redirect_valid=1, redirect_pc=0x40.
//      -> next cycle count=0, imem_q from 4/5 not pushed.
//      -> following cycle rden at 0x40,0x41; out_pc=0x40 two edges later.
//   4. count=1, deq_count=2.
//      -> pop=1, count=0 (plus any push); out_valid=2'b01 before the edge.
//   5. fetch_pc=0xFFF (ISSUE_W=2).
//      -> imem_addr lanes = 0xFFF, 0x000; next fetch_pc=0x001.
//   6. FETCH_ALIGN_EN, redirect_pc=0x23.
//      -> rden at 0x22,0x23; only 0x23 pushed (count=1); next group 0x24,0x25.

Source files
------------

// File: rtl/fetch_queue_nw.sv
// N-wide instruction fetch queue.
// Issues ISSUE_W consecutive word addresses per fetch group to the imem read ports and buffers
// the returned instructions, tagged with their PCs, in a DEPTH-entry circular queue. Decode
// pops 0..ISSUE_W of the oldest entries per cycle. A redirect flushes the queue and restarts
// fetch.
// Optional feature: define FETCH_ALIGN_EN to align fetch groups to ISSUE_W words. The first
// group after a redirect then pushes only the lanes at or above the redirect offset.
module fetch_queue_nw #(
    parameter int unsigned       ISSUE_W  = 2,
    parameter int unsigned       DEPTH    = 8,
    parameter int unsigned       ADDR_W   = 12,
    parameter int unsigned       INSN_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           redirect_valid,
    input  logic [ADDR_W-1:0]              redirect_pc,
    output logic [ISSUE_W*ADDR_W-1:0]      imem_addr,
    output logic [ISSUE_W-1:0]             imem_rden,
    input  logic [ISSUE_W*INSN_W-1:0]      imem_q,
    input  logic [$clog2(ISSUE_W+1)-1:0]   deq_count,
    output logic [ISSUE_W-1:0]             out_valid,
    output logic [ISSUE_W*INSN_W-1:0]      out_insn,
    output logic [ISSUE_W*ADDR_W-1:0]      out_pc,
    output logic [$clog2(DEPTH+1)-1:0]     count
);

    localparam int unsigned CW = $clog2(DEPTH + 1);   // occupancy width
    localparam int unsigned PW = $clog2(DEPTH);       // pointer width
    localparam int unsigned DW = $clog2(ISSUE_W + 1); // lane-count width
    localparam int unsigned SW = CW + 2;              // headroom for the space check

    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0] pend_pc_q, pend_pc_d;
    logic              pend_q, pend_d;
    logic [PW-1:0]     head_q, head_d;
    logic [PW-1:0]     tail_q, tail_d;
    logic [CW-1:0]     count_q, count_d;

    logic [INSN_W-1:0] insn_q [DEPTH];
    logic [INSN_W-1:0] insn_d [DEPTH];
    logic [ADDR_W-1:0] pc_q   [DEPTH];
    logic [ADDR_W-1:0] pc_d   [DEPTH];

    logic              fire;
    logic              push_en;
    logic [SW-1:0]     need;
    logic [CW-1:0]     deq_ext;
    logic [CW-1:0]     pop;
    logic [CW-1:0]     push_n;
    logic [DW-1:0]     push_off;
    logic [ADDR_W-1:0] redirect_target;

`ifdef FETCH_ALIGN_EN
    // Offset of the redirect target inside its group, applied to the first response only.
    logic [DW-1:0] align_off_q, align_off_d;
    logic [DW-1:0] pend_off_q, pend_off_d;

    assign redirect_target = redirect_pc & ~ADDR_W'(ISSUE_W - 1);
    assign push_off        = pend_off_q;

    // Track which lane the next response starts pushing from.
    always_comb begin
        align_off_d = align_off_q;
        pend_off_d  = pend_off_q;
        if (redirect_valid) begin
            align_off_d = DW'(redirect_pc & ADDR_W'(ISSUE_W - 1));
            pend_off_d  = '0;
        end else if (fire) begin
            pend_off_d  = align_off_q;
            align_off_d = '0;
        end
    end

    // Alignment offset registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            align_off_q <= '0;
            pend_off_q  <= '0;
        end else begin
            align_off_q <= align_off_d;
            pend_off_q  <= pend_off_d;
        end
    end
`else
    assign redirect_target = redirect_pc;
    assign push_off        = '0;
`endif

    // Issue decision and push/pop amounts; issue uses pre-dequeue occupancy.
    always_comb begin
        need    = SW'(count_q) + (pend_q ? SW'(ISSUE_W) : '0) + SW'(ISSUE_W);
        fire    = !reset && !redirect_valid && (need <= SW'(DEPTH));
        push_en = pend_q && !redirect_valid;
        push_n  = push_en ? (CW'(ISSUE_W) - CW'(push_off)) : '0;
        deq_ext = CW'(deq_count);
        pop     = (deq_ext < count_q) ? deq_ext : count_q;
    end

    // Next state for fetch PC, pending flag, pointers and occupancy.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        pend_pc_d  = pend_pc_q;
        pend_d     = fire;
        head_d     = head_q + PW'(pop);
        tail_d     = tail_q + PW'(push_n);
        count_d    = count_q + push_n - pop;
        if (fire) begin
            fetch_pc_d = fetch_pc_q + ADDR_W'(ISSUE_W);
            pend_pc_d  = fetch_pc_q;
        end
        if (redirect_valid) begin
            fetch_pc_d = redirect_target;
            head_d     = '0;
            tail_d     = '0;
            count_d    = '0;
        end
    end

    // Write returned lanes into the queue in lane order starting at tail.
    always_comb begin
        logic [PW-1:0] widx;
        insn_d = insn_q;
        pc_d   = pc_q;
        widx   = '0;
        for (int i = 0; i < ISSUE_W; i++) begin
            if (push_en && (DW'(i) >= push_off)) begin
                widx         = tail_q + PW'(i) - PW'(push_off);
                insn_d[widx] = imem_q[i*INSN_W +: INSN_W];
                pc_d[widx]   = pend_pc_q + ADDR_W'(i);
            end
        end
    end

    // Control state registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fetch_pc_q <= RESET_PC;
            pend_pc_q  <= '0;
            pend_q     <= 1'b0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            pend_pc_q  <= pend_pc_d;
            pend_q     <= pend_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
        end
    end

    // Queue storage.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                insn_q[i] <= '0;
                pc_q[i]   <= '0;
            end
        end else begin
            insn_q <= insn_d;
            pc_q   <= pc_d;
        end
    end

    // Imem request lanes and decode-facing output lanes.
    always_comb begin
        logic [PW-1:0] ridx;
        imem_rden = {ISSUE_W{fire}};
        imem_addr = '0;
        out_valid = '0;
        out_insn  = '0;
        out_pc    = '0;
        ridx      = '0;
        for (int i = 0; i < ISSUE_W; i++) begin
            imem_addr[i*ADDR_W +: ADDR_W] = fetch_pc_q + ADDR_W'(i);
            ridx                          = head_q + PW'(i);
            out_valid[i]                  = !reset && (CW'(i) < count_q);
            out_insn[i*INSN_W +: INSN_W]  = insn_q[ridx];
            out_pc[i*ADDR_W +: ADDR_W]    = pc_q[ridx];
        end
    end

    assign count = count_q;

endmodule
